// File: rtl/seq_det_pkg.sv
// Shared constants and sizing helper for the parametrised serial-pattern detector.
package seq_det_pkg;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 32;

    // Ceiling log2, never less than 1 so a counter always has at least one bit.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         sat
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign sat = (cnt_q == {W{1'b1}});

endmodule

// File: rtl/seq_detector_param.sv
// Mealy detector for a run-time loadable PAT_W-bit serial pattern, with optional
// non-overlapping matching, a bit-valid qualifier, registered hit and hit counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    input  logic             en,
    input  logic             in,
    input  logic             clr_cnt,
    output logic             out,
    output logic             out_q,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int FILL_W = clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  pat_q, pat_d;
    logic              ovl_q, ovl_d;
    logic [PAT_W-2:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              hit_q;
    logic [PAT_W-1:0]  window;
    logic              hit;

    // The live bit completes the window, so a hit is visible in the same cycle.
    assign window = {hist_q, in};
    assign hit    = ~rst & en & ~cfg_load & (fill_q == FILL_FULL) & (window == pat_q);

    always_comb begin
        pat_d  = pat_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        if (cfg_load) begin
            pat_d  = pattern;
            ovl_d  = overlap;
            fill_d = '0;
        end else if (en) begin
            hist_d = window[PAT_W-2:0];
            if (hit && !ovl_q) begin
                fill_d = '0;
            end else if (fill_q != FILL_FULL) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q  <= '0;
            ovl_q  <= 1'b1;
            hist_q <= '0;
            fill_q <= '0;
            hit_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            hit_q  <= hit;
        end
    end

    assign out   = hit;
    assign out_q = hit_q;

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hit),
        .clr (clr_cnt),
        .cnt (match_cnt),
        .sat (cnt_sat)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: stimulus pushes model expectations, a negedge monitor pops and compares.
module tb_seq_detector_param;

    localparam int PAT_W   = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_load = 1'b0;
    logic [PAT_W-1:0] pattern = '0;
    logic             overlap = 1'b0;
    logic             en = 1'b0;
    logic             in_b = 1'b0;
    logic             clr_cnt = 1'b0;
    logic             out_b;
    logic             out_q;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    seq_detector_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_load  (cfg_load),
        .pattern   (pattern),
        .overlap   (overlap),
        .en        (en),
        .in        (in_b),
        .clr_cnt   (clr_cnt),
        .out       (out_b),
        .out_q     (out_q),
        .match_cnt (match_cnt),
        .cnt_sat   (cnt_sat)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             out;
        logic             outq;
        logic [CNT_W-1:0] cnt;
        logic             sat;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   dut_hits = 0;

    // Reference model: the list of valid bits seen since the last flush.
    logic             m_bits[$];
    logic [PAT_W-1:0] m_pat;
    logic             m_ovl;
    int               m_cnt;
    logic             m_outq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic model_hit(input logic e, input logic c, input logic b);
        logic [PAT_W-1:0] w;
        int               n;
        if (!e || c || rst) return 1'b0;
        n = m_bits.size();
        if (n < PAT_W - 1) return 1'b0;
        w = '0;
        for (int i = n - (PAT_W - 1); i < n; i++) w = {w[PAT_W-2:0], m_bits[i]};
        w = {w[PAT_W-2:0], b};
        return (w == m_pat);
    endfunction

    task automatic model_reset();
        m_bits.delete();
        m_pat  = '0;
        m_ovl  = 1'b1;
        m_cnt  = 0;
        m_outq = 1'b0;
    endtask

    task automatic step(input logic c, input logic [PAT_W-1:0] p, input logic o,
                        input logic e, input logic b, input logic clr);
        logic h;
        exp_t x;
        cfg_load = c; pattern = p; overlap = o; en = e; in_b = b; clr_cnt = clr;
        h      = model_hit(e, c, b);
        x.out  = h;
        x.outq = m_outq;
        x.cnt  = m_cnt[CNT_W-1:0];
        x.sat  = (m_cnt == CNT_MAX);
        sb.push_back(x);
        @(posedge clk);
        m_outq = h;
        if (clr) m_cnt = 0;
        else if (h && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        if (c) begin
            m_bits.delete();
            m_pat = p;
            m_ovl = o;
        end else if (e) begin
            if (h && !m_ovl) m_bits.delete();
            else m_bits.push_back(b);
            if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
        end
        #1;
    endtask

    // Reset asserted mid-cycle with a live valid bit: everything must read zero.
    task automatic do_reset();
        exp_t x;
        cfg_load = 1'b0; clr_cnt = 1'b0; en = 1'b1; in_b = 1'b1;
        rst = 1'b1;
        model_reset();
        x = '0;
        sb.push_back(x);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        logic [31:0] v;
        v = bits;
        for (int i = n - 1; i >= 0; i--) step(1'b0, '0, 1'b0, 1'b1, v[i], 1'b0);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                $display("txn t=%0t rst=%0b cfg=%0b en=%0b in=%0b | out=%0b out_q=%0b cnt=%0d sat=%0b",
                         $time, rst, cfg_load, en, in_b, out_b, out_q, match_cnt, cnt_sat);
                check("out", 32'(out_b), 32'(x.out));
                check("out_q", 32'(out_q), 32'(x.outq));
                check("match_cnt", 32'(match_cnt), 32'(x.cnt));
                check("cnt_sat", 32'(cnt_sat), 32'(x.sat));
                if (out_b === 1'b1) dut_hits++;
            end
        end
    end

    initial begin : stimulus
        int h0;
        int r;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // T1: overlapping 1011 on 1011011
        step(1'b1, 4'b1011, 1'b1, 1'b0, 1'b0, 1'b1);
        h0 = dut_hits;
        send_bits(32'b1011011, 7);
        check("T1 hits", 32'(dut_hits - h0), 32'd2);
        check("T1 cnt", 32'(match_cnt), 32'd2);

        // T2: non-overlapping
        step(1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b1);
        h0 = dut_hits;
        send_bits(32'b1011011, 7);
        check("T2 hits", 32'(dut_hits - h0), 32'd1);
        check("T2 cnt", 32'(match_cnt), 32'd1);

        // T3: en gaps are transparent
        step(1'b1, 4'b1011, 1'b1, 1'b0, 1'b0, 1'b1);
        h0 = dut_hits;
        send_bits(32'b10, 2);
        gap(3);
        send_bits(32'b11011, 5);
        check("T3 hits", 32'(dut_hits - h0), 32'd2);

        // T4: reset mid-pattern, then reset pattern (0000, overlap on) is live
        step(1'b1, 4'b1011, 1'b1, 1'b0, 1'b0, 1'b1);
        send_bits(32'b101, 3);
        do_reset();
        h0 = dut_hits;
        send_bits(32'b00000, 5);
        check("T4 reset pattern hits", 32'(dut_hits - h0), 32'd2);
        step(1'b1, 4'b1011, 1'b1, 1'b0, 1'b0, 1'b1);
        h0 = dut_hits;
        send_bits(32'b1011, 4);
        check("T4 hits", 32'(dut_hits - h0), 32'd1);

        // T5: saturation and clear-on-hit
        step(1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
        h0 = dut_hits;
        send_bits(32'hFF, 8);
        check("T5 hits", 32'(dut_hits - h0), 32'd5);
        check("T5 cnt", 32'(match_cnt), 32'(CNT_MAX));
        check("T5 sat", 32'(cnt_sat), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("T5 clr on hit", 32'(match_cnt), 32'd0);

        // T6: reload flushes history; the load cycle's bit is discarded
        step(1'b1, 4'b1011, 1'b1, 1'b0, 1'b0, 1'b1);
        send_bits(32'b101, 3);
        h0 = dut_hits;
        step(1'b1, 4'b0110, 1'b1, 1'b1, 1'b1, 1'b0);
        send_bits(32'b0110, 4);
        check("T6 hits", 32'(dut_hits - h0), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) do_reset();
            else step(1'(r < 6), PAT_W'($urandom), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      1'(r >= 6 && r < 9));
        end

        repeat (2) @(negedge clk);
        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
